raster_region_scanner: RTL and testbench
========================================

# raster_region_scanner

Parametrised raster scanner for the pixel plotter: on a start request it walks every pixel of a configurable screen in raster order, emitting one coordinate per cycle. For each of up to NUM_REGIONS rectangular sprite regions it flags whether the current pixel is inside, and supplies that region's row-major ROM address. It sits between the game-state controller and the per-pixel colour mux. It replaces hard-coded frame counters and per-sprite address counters with one block that supports clipping, abort and per-frame latching of region geometry.

## Interface
- SCREEN_W, 160, pixels per row
- SCREEN_H, 120, rows per frame
- X_W, 8, width of X coordinates and region widths
- Y_W, 8, width of Y coordinates and region heights
- NUM_REGIONS, 4, number of sprite regions
- ADDR_W, 13, width of each region ROM address
- clk  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  terminate scan (e.g. state change, spacebar)
- region_en  in  NUM_REGIONS  per-region enable
- region_x  in  NUM_REGIONS*X_W  left edge; region i at [i*X_W +: X_W]
- region_y  in  NUM_REGIONS*Y_W  top edge, same packing
- region_w  in  NUM_REGIONS*X_W  width in pixels
- region_h  in  NUM_REGIONS*Y_W  height in pixels
- pix_x  out  X_W  current X
- pix_y  out  Y_W  current Y
- pix_valid  out  1  pix_x/pix_y/region outputs valid this cycle
- region_hit  out  NUM_REGIONS  pixel inside region i
- region_addr  out  NUM_REGIONS*ADDR_W  row-major offset within region i
- busy  out  1  scan in progress, including the done cycle
- done  out  1  one-cycle end-of-frame pulse

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and abort=0 → SCAN.
  - Latch region_en/x/y/w/h into internal copies. Changes to these inputs during a frame have no effect until the next start.
  - Clear the coordinate and address state.
- SCAN:
  - Present the pixel with pix_valid=1.
  - Advance X. At X=SCREEN_W-1, wrap X to 0 and increment Y.
  - At pixel (SCREEN_W-1, SCREEN_H-1), go to DONE.
  - abort=1 → DONE next cycle; the pixel of that cycle is still presented.
  - start is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- Hit test, per region:
  - Hit when en & rx≤x<rx+w & ry≤y<ry+h.
  - Bounds are computed at X_W+1 / Y_W+1 bits, so rx+w beyond the screen never wraps.
  - w=0 or h=0 → never hits.
- Address, per region:
  - addr = row_base + (x − rx), modulo 2^ADDR_W. No multiplier.
  - row_base starts at 0 each frame.
  - row_base gains w at the end of every row whose y lies inside [ry, ry+h).
  - This keeps addresses correct for regions clipped on the right or bottom.
  - When not hit, region_addr holds its last value (0 after start).
- Overlapping regions hit independently. Priority is decided downstream.
- abort and start together in IDLE: stay IDLE.

## Timing
- Reset (resetn=0 at a posedge): state IDLE. pix_x, pix_y, pix_valid, region_hit, region_addr, busy and done are all 0 on the next cycle. start is ignored while resetn=0.
- All outputs are registered and mutually aligned: region_hit/region_addr describe pix_x/pix_y of the same cycle.
- start sampled at edge k:
  - First pixel (0,0) valid at cycle k+1.
  - pix_valid high for exactly SCREEN_W*SCREEN_H consecutive cycles.
  - done at cycle k+1+SCREEN_W*SCREEN_H.
- busy is high from k+1 through the done cycle. A new start is accepted the cycle after done.
- abort sampled at edge m during SCAN: pix_valid=0 and done=1 at cycle m+1; busy drops at m+2.
- Reset mid-scan takes effect at the next edge with no done pulse.

## Test plan
- Defaults, no regions enabled, single start pulse:
  - 19200 valid cycles in raster order, ending at (159,119).
  - done once, 19201 cycles after start. region_hit never set.
- Region 0 = (22,11), w=118, h=61:
  - 7198 hits.
  - (22,11) → addr 0; (139,11) → 117; (22,12) → 118; (139,71) → 7197.
- Region 1 = (150,115), w=20, h=10 (clipped on both axes):
  - 50 hits.
  - (150,115) → 0; (150,116) → 20; (159,119) → 89.
- Region 2 w=0 enabled, and region 3 disabled overlapping region 0: neither ever hits; region 0 unaffected.
- Abort and start rules:
  - Abort at pixel (5,3): pix_valid low the next cycle, done one cycle, busy low after.
  - A new start restarts at (0,0) with addr 0.
  - start during SCAN is ignored.
- Reset and mid-frame parameter changes:
  - resetn low at pixel (80,60): all outputs 0 the next cycle, no done pulse.
  - Changing region_x mid-frame alters nothing until the next start.

Source files
------------

// File: rtl/raster_region_scanner.sv
// Raster-order pixel walker with per-region hit flags and row-major ROM addresses.
// Region geometry is captured at frame start, so changes during a frame are ignored.
module raster_region_scanner #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_REGIONS-1:0]        region_en,
  input  logic [NUM_REGIONS*X_W-1:0]    region_x,
  input  logic [NUM_REGIONS*Y_W-1:0]    region_y,
  input  logic [NUM_REGIONS*X_W-1:0]    region_w,
  input  logic [NUM_REGIONS*Y_W-1:0]    region_h,
  output logic [X_W-1:0]                pix_x,
  output logic [Y_W-1:0]                pix_y,
  output logic                          pix_valid,
  output logic [NUM_REGIONS-1:0]        region_hit,
  output logic [NUM_REGIONS*ADDR_W-1:0] region_addr,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned XE = X_W + 1;
  localparam int unsigned YE = Y_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                       state;
  logic [NUM_REGIONS-1:0]       latEn;
  logic [NUM_REGIONS*X_W-1:0]   latX;
  logic [NUM_REGIONS*Y_W-1:0]   latY;
  logic [NUM_REGIONS*X_W-1:0]   latW;
  logic [NUM_REGIONS*Y_W-1:0]   latH;
  logic [ADDR_W-1:0]            rowBase [NUM_REGIONS];

  logic [NUM_REGIONS-1:0]       srcEn;
  logic [NUM_REGIONS*X_W-1:0]   srcX;
  logic [NUM_REGIONS*Y_W-1:0]   srcY;
  logic [NUM_REGIONS*X_W-1:0]   srcW;
  logic [NUM_REGIONS*Y_W-1:0]   srcH;
  logic [X_W-1:0]               rx [NUM_REGIONS];
  logic [Y_W-1:0]               ry [NUM_REGIONS];
  logic [X_W-1:0]               rw [NUM_REGIONS];
  logic [Y_W-1:0]               rh [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]       rowIn;
  logic [ADDR_W-1:0]            nxtBase [NUM_REGIONS];
  logic [ADDR_W-1:0]            nxtAddr [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]       nxtHit;
  logic [X_W-1:0]               nx;
  logic [Y_W-1:0]               ny;
  logic                         lastX;
  logic                         lastPix;

  // Next pixel and its region results; in IDLE the live inputs feed pixel (0,0).
  always_comb begin
    lastX   = (pix_x == X_W'(SCREEN_W - 1));
    lastPix = lastX && (pix_y == Y_W'(SCREEN_H - 1));
    if (state == IDLE) begin
      srcEn = region_en;
      srcX  = region_x;
      srcY  = region_y;
      srcW  = region_w;
      srcH  = region_h;
      nx    = '0;
      ny    = '0;
    end else begin
      srcEn = latEn;
      srcX  = latX;
      srcY  = latY;
      srcW  = latW;
      srcH  = latH;
      nx    = lastX ? '0 : X_W'(pix_x + X_W'(1));
      ny    = lastX ? Y_W'(pix_y + Y_W'(1)) : pix_y;
    end
    for (int i = 0; i < NUM_REGIONS; i++) begin
      rx[i] = srcX[i*X_W +: X_W];
      ry[i] = srcY[i*Y_W +: Y_W];
      rw[i] = srcW[i*X_W +: X_W];
      rh[i] = srcH[i*Y_W +: Y_W];
      rowIn[i] = (pix_y >= ry[i]) && (YE'(pix_y) < YE'(YE'(ry[i]) + YE'(rh[i])));
      // Row base advances by the full width after every covered row, clipped or not.
      if (state == IDLE)
        nxtBase[i] = '0;
      else if (lastX && rowIn[i])
        nxtBase[i] = ADDR_W'(rowBase[i] + ADDR_W'(rw[i]));
      else
        nxtBase[i] = rowBase[i];
      nxtHit[i] = srcEn[i]
                  && (nx >= rx[i]) && (XE'(nx) < XE'(XE'(rx[i]) + XE'(rw[i])))
                  && (ny >= ry[i]) && (YE'(ny) < YE'(YE'(ry[i]) + YE'(rh[i])));
      nxtAddr[i] = ADDR_W'(nxtBase[i] + ADDR_W'(X_W'(nx - rx[i])));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      region_hit  <= '0;
      region_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      latEn       <= '0;
      latX        <= '0;
      latY        <= '0;
      latW        <= '0;
      latH        <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) rowBase[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          latEn      <= region_en;
          latX       <= region_x;
          latY       <= region_y;
          latW       <= region_w;
          latH       <= region_h;
          pix_x      <= '0;
          pix_y      <= '0;
          pix_valid  <= 1'b0;
          region_hit <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
          for (int i = 0; i < NUM_REGIONS; i++) rowBase[i] <= '0;
          if (start && !abort) begin
            state      <= SCAN;
            pix_valid  <= 1'b1;
            busy       <= 1'b1;
            region_hit <= nxtHit;
            for (int i = 0; i < NUM_REGIONS; i++)
              region_addr[i*ADDR_W +: ADDR_W] <= nxtHit[i] ? nxtAddr[i] : '0;
          end
        end
        SCAN: begin
          if (abort || lastPix) begin
            state      <= DONE;
            pix_valid  <= 1'b0;
            region_hit <= '0;
            done       <= 1'b1;
          end else begin
            pix_x      <= nx;
            pix_y      <= ny;
            region_hit <= nxtHit;
            for (int i = 0; i < NUM_REGIONS; i++) begin
              rowBase[i] <= nxtBase[i];
              if (nxtHit[i]) region_addr[i*ADDR_W +: ADDR_W] <= nxtAddr[i];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          pix_x <= '0;
          pix_y <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_region_scanner.sv
// Directed bench for raster_region_scanner: full frames, clipped regions, abort, reset.
module tb_raster_region_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [3:0]  region_en;
  logic [31:0] region_x;
  logic [31:0] region_y;
  logic [31:0] region_w;
  logic [31:0] region_h;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_valid;
  logic [3:0]  region_hit;
  logic [51:0] region_addr;
  logic        busy;
  logic        done;

  int nChecks = 0;
  int nFail   = 0;

  int validCnt, orderErr, busyErr, strayHit, doneCnt, doneCyc, seenDone;
  int hitCnt [4];
  logic [7:0]  lastPx, lastPy;
  logic [12:0] addrMem [4][160][120];

  raster_region_scanner dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .region_en(region_en), .region_x(region_x), .region_y(region_y),
    .region_w(region_w), .region_h(region_h),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .region_hit(region_hit), .region_addr(region_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start, then follow the frame to done, gathering raster statistics.
  task automatic walkFrame(input bit mutate);
    int cycles;
    logic [7:0] ex, ey;
    validCnt = 0; orderErr = 0; busyErr = 0; strayHit = 0;
    doneCnt = 0; doneCyc = 0; seenDone = 0;
    for (int r = 0; r < 4; r++) hitCnt[r] = 0;
    ex = 0; ey = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    while (!seenDone && cycles < 20000) begin
      if (mutate && cycles == 2) begin
        region_x  = '0;
        region_en = 4'hF;
        region_w  = 32'hFFFF_FFFF;
      end
      if (pix_valid) begin
        validCnt++;
        if (pix_x !== ex || pix_y !== ey) orderErr++;
        if (ex == 8'd159) begin ex = 0; ey = ey + 8'd1; end
        else ex = ex + 8'd1;
        if (!busy) busyErr++;
        lastPx = pix_x;
        lastPy = pix_y;
        for (int r = 0; r < 4; r++) begin
          if (region_hit[r]) hitCnt[r]++;
          if (pix_x < 160 && pix_y < 120) addrMem[r][pix_x][pix_y] = region_addr[r*13 +: 13];
        end
      end else if (region_hit != 0) strayHit++;
      if (done) begin
        doneCnt++;
        doneCyc = cycles;
        seenDone = 1;
        if (!busy) busyErr++;
      end else begin
        tick();
        cycles++;
      end
    end
    chk("frame_done_seen", 32'(seenDone), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; abort = 1'b0;
    region_en = '0; region_x = '0; region_y = '0; region_w = '0; region_h = '0;
    tick(); tick();
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_pix",   32'({pix_x, pix_y}), 0);
    chk("rst_hit",   32'(region_hit), 0);
    chk("rst_addr",  32'(region_addr[31:0] | region_addr[51:32]), 0);
    start = 1'b0; resetn = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Frame 1: no regions enabled.
    walkFrame(0);
    chk("f1_valid_cnt", 32'(validCnt), 19200);
    chk("f1_order",     32'(orderErr), 0);
    chk("f1_last_pix",  32'({lastPx, lastPy}), 32'({8'd159, 8'd119}));
    chk("f1_done_cyc",  32'(doneCyc), 19201);
    chk("f1_busy",      32'(busyErr), 0);
    chk("f1_hits",      32'(hitCnt[0] + hitCnt[1] + hitCnt[2] + hitCnt[3]), 0);
    chk("f1_stray",     32'(strayHit), 0);
    tick();
    chk("f1_after_busy", 32'(busy), 0);
    chk("f1_after_done", 32'(done), 0);

    // Frame 2: regions 0/1 live, region 2 zero width, region 3 disabled; inputs mutate mid-frame.
    region_en = 4'b0111;
    region_x  = {8'd30, 8'd10, 8'd150, 8'd22};
    region_y  = {8'd20, 8'd10, 8'd115, 8'd11};
    region_w  = {8'd10, 8'd0,  8'd20,  8'd118};
    region_h  = {8'd10, 8'd5,  8'd10,  8'd61};
    walkFrame(1);
    chk("f2_valid_cnt", 32'(validCnt), 19200);
    chk("f2_done_cyc",  32'(doneCyc), 19201);
    chk("f2_hit0",      32'(hitCnt[0]), 7198);
    chk("f2_hit1",      32'(hitCnt[1]), 50);
    chk("f2_hit2",      32'(hitCnt[2]), 0);
    chk("f2_hit3",      32'(hitCnt[3]), 0);
    chk("f2_stray",     32'(strayHit), 0);
    chk("r0_22_11",     32'(addrMem[0][22][11]), 0);
    chk("r0_139_11",    32'(addrMem[0][139][11]), 117);
    chk("r0_22_12",     32'(addrMem[0][22][12]), 118);
    chk("r0_139_71",    32'(addrMem[0][139][71]), 7197);
    chk("r0_hold_140_71", 32'(addrMem[0][140][71]), 7197);
    chk("r1_150_115",   32'(addrMem[1][150][115]), 0);
    chk("r1_150_116",   32'(addrMem[1][150][116]), 20);
    chk("r1_159_119",   32'(addrMem[1][159][119]), 89);
    tick();

    // Abort frame: region 0 = 4x4 at origin.
    region_en = 4'b0001;
    region_x = '0; region_y = '0;
    region_w = 32'd4; region_h = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    chk("ab_first_pix", 32'({pix_valid, pix_x, pix_y}), 32'({1'b1, 8'd0, 8'd0}));
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("scan_start_ignored", 32'({pix_valid, pix_x, pix_y}), 32'({1'b1, 8'd3, 8'd0}));
    for (int n = 0; n < 1000 && !(pix_x == 8'd5 && pix_y == 8'd3); n++) tick();
    chk("ab_reach_5_3", 32'({pix_x, pix_y}), 32'({8'd5, 8'd3}));
    chk("ab_hold_addr", 32'({region_hit[0], region_addr[12:0]}), 32'({1'b0, 13'd15}));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_valid", 32'(pix_valid), 0);
    chk("ab_done",  32'(done), 1);
    chk("ab_busy",  32'(busy), 1);
    tick();
    chk("ab_done_end", 32'(done), 0);
    chk("ab_busy_end", 32'(busy), 0);

    // start with abort in IDLE is refused.
    start = 1'b1; abort = 1'b1; tick();
    chk("ab_start_idle", 32'({busy, pix_valid}), 0);
    abort = 1'b0; region_en = 4'b0000;
    tick(); start = 1'b0;
    chk("restart_pix",  32'({pix_valid, pix_x, pix_y}), 32'({1'b1, 8'd0, 8'd0}));
    chk("restart_addr", 32'(region_addr[12:0]), 0);

    // Reset in the middle of the frame.
    for (int n = 0; n < 20000 && !(pix_x == 8'd80 && pix_y == 8'd60); n++) tick();
    chk("mid_reach_80_60", 32'({pix_x, pix_y}), 32'({8'd80, 8'd60}));
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("mid_rst_outs", 32'({pix_valid, busy, done, region_hit, pix_x, pix_y}), 0);
    doneCnt = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (done) doneCnt++;
    end
    chk("mid_rst_no_done", 32'(doneCnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
